// File: rtl/dig_pkg.sv
// Shared constants, source codes and converter state encoding for the display arbiter.
package dig_pkg;

   localparam int          DIGITS  = 8;
   localparam logic [26:0] BCD_MAX = 27'd99_999_999;

   localparam logic [1:0] SRC_SCORE = 2'd0;
   localparam logic [1:0] SRC_BEST  = 2'd1;
   localparam logic [1:0] SRC_MSG   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: LOAD samples din, WIDTH SHIFT cycles, DONE presents the BCD result.
// The caller keeps din below 10**DIGITS; a tag travels alongside the sampled value.
module bin2bcd_seq
   import dig_pkg::*;
#(
   parameter int WIDTH  = 27,
   parameter int DIGITS = 8,
   parameter int TAG_W  = 2
) (
   input  logic                dig_clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    din,
   input  logic [TAG_W-1:0]    tag_in,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic [TAG_W-1:0]    tag_out
);

   localparam int SW = 4*DIGITS + WIDTH;
   localparam int CW = $clog2(WIDTH);

   conv_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sr_q, sr_d, sr_adj;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      tag_d   = tag_q;
      sr_adj  = sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_q[WIDTH+4*i +: 4] >= 4'd5) begin
            sr_adj[WIDTH+4*i +: 4] = sr_q[WIDTH+4*i +: 4] + 4'd3;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            sr_d    = SW'(din);
            tag_d   = tag_in;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sr_d  = {sr_adj[SW-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Status flags are registered from the next state so they line up with state_q.
      busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge dig_clk) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values; reset is synchronous.
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         tag_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd     = sr_q[WIDTH +: 4*DIGITS];
   assign tag_out = tag_q;

endmodule

// File: rtl/dig_display_arbiter.sv
// Chooses among score, best score and a held message, converts it to BCD back-to-back,
// and publishes digits, leading-zero blank mask and source id to the scan driver.
module dig_display_arbiter
   import dig_pkg::*;
#(
   parameter int WIDTH        = 27,
   parameter int DIGITS       = 8,
   parameter int ROTATE_TICKS = 1000,
   parameter int HOLD_TICKS   = 2000
) (
   input  logic                dig_clk,
   input  logic                rst,
   input  logic                tick,
   input  logic [WIDTH-1:0]    score,
   input  logic [WIDTH-1:0]    best,
   input  logic                msg_req,
   input  logic [WIDTH-1:0]    msg_val,
   output logic                msg_ack,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]   blank,
   output logic [1:0]          src_id,
   output logic                upd,
   output logic                busy
);

   localparam int RW = $clog2(ROTATE_TICKS + 1);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   logic              msg_active_q, msg_active_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [WIDTH-1:0]  msg_val_q, msg_val_d;
   logic              rot_best_q, rot_best_d;
   logic [RW-1:0]     rot_cnt_q, rot_cnt_d;
   logic              msg_ack_q, msg_ack_d;
   logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
   logic [DIGITS-1:0] blank_q, blank_d, blank_mask;
   logic [1:0]        src_id_q, src_id_d;
   logic              upd_q, upd_d;

   logic [WIDTH-1:0]  sel_val, load_val;
   logic [1:0]        sel_src;
   logic              all_zero;
   logic              conv_busy, conv_done;
   logic [4*DIGITS-1:0] conv_bcd;
   logic [1:0]        conv_tag;

   // Message and rotation scheduling; a request beats both hold expiry and a same-cycle tick.
   always_comb begin
      msg_active_d = msg_active_q;
      hold_d       = hold_q;
      msg_val_d    = msg_val_q;
      rot_best_d   = rot_best_q;
      rot_cnt_d    = rot_cnt_q;
      msg_ack_d    = msg_req;
      if (!msg_active_q && tick) begin
         if (rot_cnt_q == RW'(ROTATE_TICKS-1)) begin
            rot_best_d = ~rot_best_q;
            rot_cnt_d  = '0;
         end else begin
            rot_cnt_d = rot_cnt_q + 1'b1;
         end
      end
      if (msg_req) begin
         msg_val_d    = msg_val;
         hold_d       = HW'(HOLD_TICKS);
         msg_active_d = 1'b1;
      end else if (msg_active_q && tick) begin
         if (hold_q <= HW'(1)) begin
            msg_active_d = 1'b0;
            hold_d       = '0;
            rot_best_d   = 1'b0;
            rot_cnt_d    = '0;
         end else begin
            hold_d = hold_q - 1'b1;
         end
      end
   end

   always_comb begin
      if (msg_active_q) begin
         sel_val = msg_val_q;
         sel_src = SRC_MSG;
      end else if (rot_best_q) begin
         sel_val = best;
         sel_src = SRC_BEST;
      end else begin
         sel_val = score;
         sel_src = SRC_SCORE;
      end
      load_val = (sel_val > WIDTH'(BCD_MAX)) ? WIDTH'(BCD_MAX) : sel_val;
   end

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS),
      .TAG_W  (2)
   ) u_conv (
      .dig_clk (dig_clk),
      .rst     (rst),
      .start   (1'b1),
      .din     (load_val),
      .tag_in  (sel_src),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd     (conv_bcd),
      .tag_out (conv_tag)
   );

   // Scan from the top digit down: a digit blanks only if it and everything above it is zero.
   always_comb begin
      blank_mask = '0;
      all_zero   = 1'b1;
      for (int i = DIGITS-1; i >= 1; i--) begin
         all_zero      = all_zero & (conv_bcd[4*i +: 4] == 4'd0);
         blank_mask[i] = all_zero;
      end
      bcd_out_d = bcd_out_q;
      blank_d   = blank_q;
      src_id_d  = src_id_q;
      upd_d     = conv_done;
      if (conv_done) begin
         bcd_out_d = conv_bcd;
         blank_d   = blank_mask;
         src_id_d  = conv_tag;
      end
   end

   always_ff @(posedge dig_clk) begin
      if (rst) begin
         msg_active_q <= 1'b0;
         hold_q       <= '0;
         msg_val_q    <= '0;
         rot_best_q   <= 1'b0;
         rot_cnt_q    <= '0;
         msg_ack_q    <= 1'b0;
         bcd_out_q    <= '0;
         blank_q      <= BLANK_RST;
         src_id_q     <= SRC_SCORE;
         upd_q        <= 1'b0;
      end else begin
         msg_active_q <= msg_active_d;
         hold_q       <= hold_d;
         msg_val_q    <= msg_val_d;
         rot_best_q   <= rot_best_d;
         rot_cnt_q    <= rot_cnt_d;
         msg_ack_q    <= msg_ack_d;
         bcd_out_q    <= bcd_out_d;
         blank_q      <= blank_d;
         src_id_q     <= src_id_d;
         upd_q        <= upd_d;
      end
   end

   assign msg_ack = msg_ack_q;
   assign bcd_out = bcd_out_q;
   assign blank   = blank_q;
   assign src_id  = src_id_q;
   assign upd     = upd_q;
   assign busy    = conv_busy;

endmodule

// File: tb/tb_dig_display_arbiter.sv
// Bench for dig_display_arbiter: a schedule-level model checked every cycle plus directed literal checks.
module tb_dig_display_arbiter;

   localparam int WIDTH  = 27;
   localparam int ROT    = 4;
   localparam int HOLD   = 3;
   localparam int PERIOD = WIDTH + 3;

   logic        dig_clk = 1'b0;
   logic        rst     = 1'b1;
   logic        tick    = 1'b0;
   logic        msg_req = 1'b0;
   logic [26:0] score   = '0;
   logic [26:0] best    = '0;
   logic [26:0] msg_val = '0;
   logic        msg_ack, upd, busy;
   logic [31:0] bcd_out;
   logic [7:0]  blank;
   logic [1:0]  src_id;

   always #5 dig_clk = ~dig_clk;

   dig_display_arbiter #(
      .WIDTH        (WIDTH),
      .DIGITS       (8),
      .ROTATE_TICKS (ROT),
      .HOLD_TICKS   (HOLD)
   ) dut (
      .dig_clk (dig_clk),
      .rst     (rst),
      .tick    (tick),
      .score   (score),
      .best    (best),
      .msg_req (msg_req),
      .msg_val (msg_val),
      .msg_ack (msg_ack),
      .bcd_out (bcd_out),
      .blank   (blank),
      .src_id  (src_id),
      .upd     (upd),
      .busy    (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] to_bcd(input longint v);
      logic [31:0] r;
      longint p;
      p = 1;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] to_blank(input longint v);
      logic [7:0] r;
      longint p;
      r = '0;
      p = 10;
      for (int i = 1; i < 8; i++) begin
         r[i] = (v < p);
         p = p * 10;
      end
      return r;
   endfunction

   // Model: fixed 30-cycle conversion schedule (IDLE, LOAD, 27 SHIFT, DONE) and selector rules.
   bit     m_valid = 0;
   int     m_phase, m_hold, m_rot_cnt, m_cap_src;
   bit     m_active, m_rot_best;
   longint m_msg_val, m_cap_val, m_v;
   logic [31:0] e_bcd;
   logic [7:0]  e_blank;
   logic [1:0]  e_src;
   logic        e_upd, e_busy, e_ack;

   always @(posedge dig_clk) begin
      m_valid = 1;
      if (rst) begin
         m_phase = 0; m_active = 0; m_rot_best = 0; m_hold = 0; m_rot_cnt = 0; m_msg_val = 0;
         e_bcd = '0; e_blank = 8'hFE; e_src = 2'd0; e_upd = 0; e_busy = 0; e_ack = 0;
      end else begin
         if (m_phase == 1) begin
            m_v       = m_active ? m_msg_val : (m_rot_best ? longint'(best) : longint'(score));
            m_cap_val = (m_v > 99_999_999) ? 99_999_999 : m_v;
            m_cap_src = m_active ? 2 : (m_rot_best ? 1 : 0);
         end
         e_upd = (m_phase == PERIOD - 1);
         if (e_upd) begin
            e_bcd   = to_bcd(m_cap_val);
            e_blank = to_blank(m_cap_val);
            e_src   = 2'(m_cap_src);
         end
         m_phase = (m_phase + 1) % PERIOD;
         e_busy  = (m_phase >= 1) && (m_phase <= WIDTH + 1);
         e_ack   = msg_req;
         if (!m_active && tick) begin
            if (m_rot_cnt == ROT - 1) begin
               m_rot_best = !m_rot_best;
               m_rot_cnt  = 0;
            end else begin
               m_rot_cnt++;
            end
         end
         if (msg_req) begin
            m_msg_val = longint'(msg_val);
            m_hold    = HOLD;
            m_active  = 1;
         end else if (m_active && tick) begin
            m_hold--;
            if (m_hold == 0) begin
               m_active   = 0;
               m_rot_best = 0;
               m_rot_cnt  = 0;
            end
         end
      end
   end

   always @(negedge dig_clk) begin
      if (m_valid) begin
         check("model_bcd_out", bcd_out, e_bcd);
         check("model_blank", blank, e_blank);
         check("model_src_id", src_id, e_src);
         check("model_upd", upd, e_upd);
         check("model_busy", busy, e_busy);
         check("model_msg_ack", msg_ack, e_ack);
      end
   end

   task automatic wait_upd(input int n);
      int c;
      for (int k = 0; k < n; k++) begin
         c = 0;
         @(negedge dig_clk);
         while (upd !== 1'b1 && c < 100) begin
            @(negedge dig_clk);
            c++;
         end
         if (upd !== 1'b1) check("upd_timeout", upd, 1);
      end
   endtask

   task automatic pulse_ticks(input int n);
      tick = 1'b1;
      repeat (n) @(negedge dig_clk);
      tick = 1'b0;
   endtask

   initial begin
      int c, n;
      repeat (3) @(negedge dig_clk);
      check("rst_bcd_out", bcd_out, 32'h0);
      check("rst_blank", blank, 8'hFE);
      check("rst_src_id", src_id, 2'd0);
      check("rst_upd", upd, 1'b0);
      check("rst_busy", busy, 1'b0);

      score = 27'd12345;
      rst   = 1'b0;
      c = 0;
      @(negedge dig_clk);
      while (busy !== 1'b1 && c < 50) begin @(negedge dig_clk); c++; end
      n = 0;
      while (upd !== 1'b1 && n < 100) begin @(negedge dig_clk); n++; end
      check("latency", n, 29);
      check("t2_bcd", bcd_out, 32'h00012345);
      check("t2_blank", blank, 8'hE0);
      check("t2_src", src_id, 2'd0);

      score = 27'd120_000_000;
      wait_upd(2);
      check("sat_bcd", bcd_out, 32'h99999999);
      check("sat_blank", blank, 8'h00);

      score = 27'd5;
      best  = 27'd7;
      wait_upd(1);
      pulse_ticks(4);
      wait_upd(2);
      check("rot_best_src", src_id, 2'd1);
      check("rot_best_bcd", bcd_out, 32'h7);
      check("rot_best_blank", blank, 8'hFE);
      pulse_ticks(4);
      wait_upd(2);
      check("rot_back_src", src_id, 2'd0);
      check("rot_back_bcd", bcd_out, 32'h5);

      msg_val = 27'd42;
      msg_req = 1'b1;
      @(negedge dig_clk);
      msg_req = 1'b0;
      check("ack_42", msg_ack, 1'b1);
      wait_upd(2);
      check("msg_src", src_id, 2'd2);
      check("msg_bcd", bcd_out, 32'h42);
      check("msg_blank", blank, 8'hFC);
      pulse_ticks(2);
      msg_val = 27'd43;
      msg_req = 1'b1;
      tick    = 1'b1;
      @(negedge dig_clk);
      msg_req = 1'b0;
      tick    = 1'b0;
      check("ack_43", msg_ack, 1'b1);
      pulse_ticks(2);
      wait_upd(2);
      check("msg43_src", src_id, 2'd2);
      check("msg43_bcd", bcd_out, 32'h43);
      pulse_ticks(1);
      wait_upd(2);
      check("msg_end_src", src_id, 2'd0);
      check("msg_end_bcd", bcd_out, 32'h5);

      score = 27'd999;
      wait_upd(1);
      repeat (6) @(negedge dig_clk);
      check("mid_busy_before", busy, 1'b1);
      rst = 1'b1;
      @(negedge dig_clk);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_bcd", bcd_out, 32'h0);
      check("mid_rst_blank", blank, 8'hFE);
      check("mid_rst_upd", upd, 1'b0);
      rst = 1'b0;
      wait_upd(1);
      check("after_rst_bcd", bcd_out, 32'h999);
      check("after_rst_blank", blank, 8'hF8);
      check("after_rst_src", src_id, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
